// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Each digit slot is a blanking guard phase followed by a drive phase; all outputs are registered.
module seg7_scan_controller #(
  parameter bit          simulate        = 1'b0,
  parameter int unsigned REFRESH_CNT     = 99_999,
  parameter int unsigned SIM_REFRESH_CNT = 4,
  parameter int unsigned GUARD_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] digit0,
  input  logic [4:0] digit1,
  input  logic [4:0] digit2,
  input  logic [4:0] digit3,
  input  logic [4:0] digit4,
  input  logic [4:0] digit5,
  input  logic [4:0] digit6,
  input  logic [4:0] digit7,
  input  logic [7:0] dp_in,
  input  logic [7:0] digit_en,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned N          = simulate ? SIM_REFRESH_CNT : REFRESH_CNT;
  localparam logic [16:0] DRIVE_LAST = 17'(N);
  localparam logic [16:0] GUARD_LAST = 17'(GUARD_CYCLES - 1);

  typedef enum logic {GUARD, DRIVE} state_t;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [16:0] cnt, cnt_n;
  logic        run;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n, tick_n;
  logic [4:0]  code_sel;
  logic        dp_sel, en_sel;

  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'd0:    return 7'h40;
      5'd1:    return 7'h79;
      5'd2:    return 7'h24;
      5'd3:    return 7'h30;
      5'd4:    return 7'h19;
      5'd5:    return 7'h12;
      5'd6:    return 7'h02;
      5'd7:    return 7'h78;
      5'd8:    return 7'h00;
      5'd9:    return 7'h10;
      5'd10:   return 7'h08;
      5'd11:   return 7'h03;
      5'd12:   return 7'h46;
      5'd13:   return 7'h21;
      5'd14:   return 7'h06;
      5'd15:   return 7'h0E;
      5'd16:   return 7'h7E;
      5'd17:   return 7'h7D;
      5'd18:   return 7'h7B;
      5'd19:   return 7'h77;
      5'd20:   return 7'h6F;
      5'd21:   return 7'h5F;
      5'd22:   return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb begin
    code_sel = digit0;
    case (idx)
      3'd0:    code_sel = digit0;
      3'd1:    code_sel = digit1;
      3'd2:    code_sel = digit2;
      3'd3:    code_sel = digit3;
      3'd4:    code_sel = digit4;
      3'd5:    code_sel = digit5;
      3'd6:    code_sel = digit6;
      default: code_sel = digit7;
    endcase
    dp_sel = dp_in[idx];
    en_sel = digit_en[idx];
  end

  // The output registers themselves hold the digit captured at the GUARD->DRIVE edge.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + 17'd1;
    an_n    = an;
    seg_n   = seg;
    dp_n    = dp;
    tick_n  = 1'b0;
    if (!run) begin
      // First cycle out of reset is the entry into GUARD for digit 0.
      cnt_n  = '0;
      tick_n = 1'b1;
    end else begin
      case (state)
        GUARD: begin
          if (cnt == GUARD_LAST) begin
            state_n = DRIVE;
            cnt_n   = '0;
            if (en_sel) begin
              an_n  = ~(8'b1 << idx);
              seg_n = decode(code_sel);
              dp_n  = ~dp_sel;
            end
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            state_n = GUARD;
            cnt_n   = '0;
            idx_n   = idx + 3'd1;
            an_n    = '1;
            seg_n   = '1;
            dp_n    = 1'b1;
            tick_n  = (idx == 3'd7);
          end
        end
        default: state_n = GUARD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= GUARD;
      idx        <= '0;
      cnt        <= '0;
      run        <= 1'b0;
      an         <= '1;
      seg        <= '1;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      run        <= 1'b1;
      an         <= an_n;
      seg        <= seg_n;
      dp         <= dp_n;
      frame_tick <= tick_n;
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller: a slot/frame arithmetic model queues per-cycle
// expectations, and a monitor compares them against the registered outputs.
module tb_seg7_scan_controller;

  localparam int unsigned G     = 2;
  localparam int unsigned N     = 4;
  localparam int unsigned SLOT  = G + N + 1;
  localparam int unsigned FRAME = 8 * SLOT;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] dig [8];
  logic [7:0] dp_in, digit_en;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp, frame_tick;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t        q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned k     = 0;
  int unsigned cyc   = 0;
  logic [4:0]  lat_code;
  logic        lat_dp, lat_en;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg7_scan_controller #(.simulate(1'b1)) dut (
    .clk(clk), .reset(reset),
    .digit0(dig[0]), .digit1(dig[1]), .digit2(dig[2]), .digit3(dig[3]),
    .digit4(dig[4]), .digit5(dig[5]), .digit6(dig[6]), .digit7(dig[7]),
    .dp_in(dp_in), .digit_en(digit_en),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  function automatic logic [6:0] ref_decode(input logic [4:0] c);
    if (c < 5'd16) return glyph[c[3:0]];
    if (c < 5'd23) return ~(7'b1 << (c - 5'd16));
    return 7'h7F;
  endfunction

  // Push the expected outputs after the coming edge, given the inputs now applied.
  task automatic tick();
    exp_t        e;
    int unsigned pos, id;
    e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
    if (reset) begin
      k = 0;
    end else begin
      pos    = k % SLOT;
      id     = (k / SLOT) % 8;
      e.tick = ((k % FRAME) == 0);
      if (pos == G) begin
        lat_code = dig[id];
        lat_dp   = dp_in[id];
        lat_en   = digit_en[id];
      end
      if (pos >= G && lat_en) begin
        e.an  = ~(8'b1 << id);
        e.seg = ref_decode(lat_code);
        e.dp  = ~lat_dp;
      end
      k++;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_to(input int unsigned target);
    for (int i = 0; i < int'(FRAME) && (k % FRAME) != target; i++) tick();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if ({an, seg, dp, frame_tick} !== e) begin
          fails++;
          $display("FAIL cycle%0d outputs: got an=%h seg=%h dp=%b tick=%b, expected an=%h seg=%h dp=%b tick=%b",
                   cyc, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.tick);
        end
      end
      cyc++;
    end
  end

  initial begin
    reset    = 1'b1;
    dp_in    = 8'h00;
    digit_en = 8'hFF;
    for (int i = 0; i < 8; i++) dig[i] = 5'(i);
    repeat (3) tick();
    reset = 1'b0;

    repeat (2 * FRAME) tick();

    for (int m = 16; m <= 23; m++) begin
      dig[0] = 5'(m);
      repeat (FRAME) tick();
    end
    dig[0] = 5'd0;

    digit_en = 8'b1111_1011;
    repeat (FRAME) tick();
    digit_en = 8'hFF;

    run_to(0);
    dig[1] = 5'd3;
    dp_in  = 8'h02;
    run_to(SLOT + G + 2);
    dig[1] = 5'd8;
    repeat (2 * FRAME) tick();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0:       dig[$urandom_range(0, 7)] = 5'($urandom_range(0, 31));
          1:       digit_en[$urandom_range(0, 7)] ^= 1'b1;
          default: dp_in[$urandom_range(0, 7)] ^= 1'b1;
        endcase
      end
      tick();
    end

    run_to(5 * SLOT + G + 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2 * FRAME) tick();

    @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
